apu_envelope_length: RTL and testbench

APU_ENVELOPE_LENGTH -- requirements
Module: apu_envelope_length

---
 rtl/apu_envelope_length.sv | 137 +++++++++++++
 tb/tb_apu_envelope_length.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apu_envelope_length.sv
// apu_envelope_length: APU channel length counter with an optional volume envelope.
// Every state update is qualified by the one-clock cpu_en strobe.
// Optional feature: define APU_ENVELOPE_EN to build in the envelope generator
// (start flag, divider, decay). Without it, volume is the raw period/volume field.
module apu_envelope_length (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_en,
  input  logic       quarter_frame,
  input  logic       half_frame,
  input  logic       write_ctrl,
  input  logic [5:0] ctrl_data,
  input  logic       write_length,
  input  logic [4:0] length_index,
  input  logic       channel_enable,
  output logic [3:0] volume,
  output logic       length_active
);

  logic       halt_q;
  logic [3:0] period_q;
  logic [7:0] length_q;
  logic [7:0] length_d;
  logic [7:0] length_load;

  // Length table lookup.
  always_comb begin
    length_load = 8'd0;
    case (length_index)
      5'd0:  length_load = 8'd10;   5'd1:  length_load = 8'd254;
      5'd2:  length_load = 8'd20;   5'd3:  length_load = 8'd2;
      5'd4:  length_load = 8'd40;   5'd5:  length_load = 8'd4;
      5'd6:  length_load = 8'd80;   5'd7:  length_load = 8'd6;
      5'd8:  length_load = 8'd160;  5'd9:  length_load = 8'd8;
      5'd10: length_load = 8'd60;   5'd11: length_load = 8'd10;
      5'd12: length_load = 8'd14;   5'd13: length_load = 8'd12;
      5'd14: length_load = 8'd26;   5'd15: length_load = 8'd14;
      5'd16: length_load = 8'd12;   5'd17: length_load = 8'd16;
      5'd18: length_load = 8'd24;   5'd19: length_load = 8'd18;
      5'd20: length_load = 8'd48;   5'd21: length_load = 8'd20;
      5'd22: length_load = 8'd96;   5'd23: length_load = 8'd22;
      5'd24: length_load = 8'd192;  5'd25: length_load = 8'd24;
      5'd26: length_load = 8'd72;   5'd27: length_load = 8'd26;
      5'd28: length_load = 8'd16;   5'd29: length_load = 8'd28;
      5'd30: length_load = 8'd32;   5'd31: length_load = 8'd30;
      default: length_load = 8'd0;
    endcase
  end

  // Length next state: disable beats load, load beats the halt-gated decrement.
  // halt_q is the pre-write value, so a coincident control write does not affect this tick.
  always_comb begin
    length_d = length_q;
    if (!channel_enable) begin
      length_d = 8'd0;
    end else if (write_length) begin
      length_d = length_load;
    end else if (half_frame && !halt_q && (length_q != 8'd0)) begin
      length_d = length_q - 8'd1;
    end
  end

  // Length counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      length_q <= 8'd0;
    end else if (cpu_en) begin
      length_q <= length_d;
    end
  end

  // Control register: halt/loop and period/volume.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halt_q   <= 1'b0;
      period_q <= 4'd0;
    end else if (cpu_en && write_ctrl) begin
      halt_q   <= ctrl_data[5];
      period_q <= ctrl_data[3:0];
    end
  end

  assign length_active = (length_q != 8'd0);

`ifdef APU_ENVELOPE_EN
  logic       constant_q;
  logic       start_q;
  logic [3:0] decay_q;
  logic [3:0] divider_q;

  // Constant-volume flag from the control register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      constant_q <= 1'b0;
    end else if (cpu_en && write_ctrl) begin
      constant_q <= ctrl_data[4];
    end
  end

  // Envelope: a quarter tick consumes an existing start flag; a length write on the
  // same edge re-arms start for the following tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q   <= 1'b0;
      decay_q   <= 4'd0;
      divider_q <= 4'd0;
    end else if (cpu_en) begin
      if (quarter_frame) begin
        if (start_q) begin
          start_q   <= 1'b0;
          decay_q   <= 4'hf;
          divider_q <= period_q;
        end else if (divider_q == 4'd0) begin
          divider_q <= period_q;
          if (decay_q != 4'd0) begin
            decay_q <= decay_q - 4'd1;
          end else if (halt_q) begin
            decay_q <= 4'hf;
          end
        end else begin
          divider_q <= divider_q - 4'd1;
        end
      end
      if (write_length) begin
        start_q <= 1'b1;
      end
    end
  end

  assign volume = constant_q ? period_q : decay_q;
`else
  logic unused_constant;
  assign unused_constant = ctrl_data[4];
  assign volume = period_q;
`endif

endmodule

// File: tb/tb_apu_envelope_length.sv
// Self-checking bench for apu_envelope_length: directed scenarios plus randomized
// traffic, checked every cycle against a behavioural model of the channel rules.
module tb_apu_envelope_length;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_en = 1'b0;
  logic       quarter_frame = 1'b0;
  logic       half_frame = 1'b0;
  logic       write_ctrl = 1'b0;
  logic [5:0] ctrl_data = 6'd0;
  logic       write_length = 1'b0;
  logic [4:0] length_index = 5'd0;
  logic       channel_enable = 1'b0;
  logic [3:0] volume;
  logic       length_active;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  int len_table [32] = '{10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
                         12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30};

  // Model state
  int m_len = 0, m_period = 0, m_decay = 0, m_div = 0;
  bit m_halt = 0, m_const = 0, m_start = 0;

  apu_envelope_length dut (
    .clk           (clk),
    .reset         (reset),
    .cpu_en        (cpu_en),
    .quarter_frame (quarter_frame),
    .half_frame    (half_frame),
    .write_ctrl    (write_ctrl),
    .ctrl_data     (ctrl_data),
    .write_length  (write_length),
    .length_index  (length_index),
    .channel_enable(channel_enable),
    .volume        (volume),
    .length_active (length_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_volume();
`ifdef APU_ENVELOPE_EN
    return m_const ? m_period : m_decay;
`else
    return m_period;
`endif
  endfunction

  task automatic model_reset();
    m_len = 0; m_period = 0; m_decay = 0; m_div = 0;
    m_halt = 0; m_const = 0; m_start = 0;
  endtask

  // One CPU-cycle update from the channel rules, using pre-edge control values.
  task automatic model_step();
    int n_len;
    if (reset || !cpu_en) return;
    n_len = m_len;
    if (!channel_enable) n_len = 0;
    else if (write_length) n_len = len_table[length_index];
    else if (half_frame && !m_halt && m_len > 0) n_len = m_len - 1;
    if (quarter_frame) begin
      if (m_start) begin
        m_start = 0; m_decay = 15; m_div = m_period;
      end else if (m_div == 0) begin
        m_div = m_period;
        if (m_decay > 0) m_decay = m_decay - 1;
        else m_decay = m_halt ? 15 : 0;
      end else begin
        m_div = m_div - 1;
      end
    end
    if (write_length) m_start = 1;
    if (write_ctrl) begin
      m_halt = ctrl_data[5]; m_const = ctrl_data[4]; m_period = int'(ctrl_data[3:0]);
    end
    m_len = n_len;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_ctrl(input logic [5:0] d);
    write_ctrl = 1'b1; ctrl_data = d; tick(); write_ctrl = 1'b0;
  endtask

  task automatic do_len(input logic [4:0] idx);
    write_length = 1'b1; length_index = idx; tick(); write_length = 1'b0;
  endtask

  task automatic hf_ticks(input int n);
    half_frame = 1'b1;
    for (int i = 0; i < n; i++) tick();
    half_frame = 1'b0;
  endtask

  task automatic qf_ticks(input int n);
    quarter_frame = 1'b1;
    for (int i = 0; i < n; i++) tick();
    quarter_frame = 1'b0;
  endtask

  // Reset pulse strictly between clock edges.
  task automatic reset_pulse();
    #1 reset = 1'b1;
    #1;
    check("async_reset_volume", volume, 8'd0);
    check("async_reset_active", length_active, 8'd0);
    model_reset();
    #1 reset = 1'b0;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      check("volume", volume, 8'(exp_volume()));
      check("length_active", length_active, 8'(m_len != 0));
    end
  end

  initial begin
    #1;
    check("reset_volume", volume, 8'd0);
    check("reset_active", length_active, 8'd0);
    tick(); tick();
    reset = 1'b0;
    cpu_en = 1'b1;
    channel_enable = 1'b1;
    cmp_en = 1'b1;

    // Full-length countdown with halt clear.
    do_ctrl(6'b000000);
    do_len(5'd1);
    check("load254_active", length_active, 8'd1);
    hf_ticks(253);
    check("len254_at1", length_active, 8'd1);
    hf_ticks(1);
    check("len254_zero", length_active, 8'd0);
    hf_ticks(1);
    check("len_no_wrap", length_active, 8'd0);

    // Halt freezes the counter; disable clears it.
    do_ctrl(6'b100000);
    do_len(5'd0);
    hf_ticks(20);
    check("halt_holds", length_active, 8'd1);
    channel_enable = 1'b0; tick(); channel_enable = 1'b1;
    check("disable_clears", length_active, 8'd0);

    // Load wins over a coincident decrement.
    do_ctrl(6'b000000);
    write_length = 1'b1; length_index = 5'd3; half_frame = 1'b1;
    tick();
    write_length = 1'b0; half_frame = 1'b0;
    hf_ticks(1);
    check("load_win_at1", length_active, 8'd1);
    hf_ticks(1);
    check("load_win_zero", length_active, 8'd0);

    // Every table entry: active until exactly its value in ticks.
    for (int i = 0; i < 32; i++) begin
      do_len(5'(i));
      hf_ticks(len_table[i] - 1);
      check("table_before_end", length_active, 8'd1);
      hf_ticks(1);
      check("table_at_end", length_active, 8'd0);
    end

    // Decay envelope, no loop, period 2.
    do_ctrl(6'b000010);
`ifdef APU_ENVELOPE_EN
    do_len(5'd0);
    qf_ticks(1);
    check("env_start15", volume, 8'd15);
    qf_ticks(3);
    check("env_14", volume, 8'd14);
    qf_ticks(42);
    check("env_zero", volume, 8'd0);
    qf_ticks(10);
    check("env_hold0", volume, 8'd0);
    // Looping envelope.
    do_ctrl(6'b100010);
    do_len(5'd0);
    qf_ticks(46);
    check("loop_zero", volume, 8'd0);
    qf_ticks(2);
    check("loop_wait", volume, 8'd0);
    qf_ticks(1);
    check("loop_15", volume, 8'd15);
`else
    check("period_vol2", volume, 8'd2);
    do_len(5'd0);
    qf_ticks(20);
    check("period_vol_qf", volume, 8'd2);
`endif
    do_ctrl(6'b010111);
    check("constant7", volume, 8'd7);

    // Async reset mid-decay.
    do_ctrl(6'b000010);
    do_len(5'd5);
    qf_ticks(10);
    reset_pulse();

    // cpu_en low: nothing moves.
    do_ctrl(6'b010101);
    do_len(5'd2);
    cpu_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      quarter_frame = $urandom_range(0, 1); half_frame = $urandom_range(0, 1);
      write_ctrl = $urandom_range(0, 1); ctrl_data = 6'($urandom);
      write_length = $urandom_range(0, 1); length_index = 5'($urandom);
      channel_enable = $urandom_range(0, 1);
      tick();
    end
    check("gated_volume", volume, 8'd5);
    check("gated_active", length_active, 8'd1);
    quarter_frame = 0; half_frame = 0; write_ctrl = 0; write_length = 0;
    channel_enable = 1'b1; cpu_en = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 5000; i++) begin
      cpu_en         = ($urandom_range(0, 3) != 0);
      quarter_frame  = ($urandom_range(0, 3) == 0);
      half_frame     = ($urandom_range(0, 3) == 0);
      write_ctrl     = ($urandom_range(0, 15) == 0);
      ctrl_data      = 6'($urandom);
      write_length   = ($urandom_range(0, 19) == 0);
      length_index   = 5'($urandom);
      channel_enable = ($urandom_range(0, 39) != 0);
      tick();
      if ($urandom_range(0, 299) == 0) reset_pulse();
    end

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
